// File: rtl/image_write.sv
// rtl/image_write.sv - writes result beats into image memory as a 2-D block (base + row*stride + col)
// Optional: IMAGE_WRITE_RELU_EN clamps negative lanes of wr_data to zero.
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] result_bus,
  input  logic                          result_last,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  typedef enum logic [0:0] {S_IDLE, S_WRITE} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [MEM_AWIDTH-1:0]         r_base;
  logic [MEM_AWIDTH-1:0]         r_stride;
  logic [CFG_DWIDTH-1:0]         r_cols;
  logic [CFG_DWIDTH-1:0]         r_rows;
  logic [MEM_AWIDTH-1:0]         r_stride_sh;
  logic [CFG_DWIDTH-1:0]         r_cols_sh;
  logic [CFG_DWIDTH-1:0]         r_rows_sh;
  logic [CFG_DWIDTH-1:0]         r_col;
  logic [CFG_DWIDTH-1:0]         r_row;
  logic [MEM_AWIDTH-1:0]         r_row_ptr;
  logic                          r_wr_val;
  logic [MEM_AWIDTH-1:0]         r_wr_addr;
  logic [GROUP_NB*IMG_WIDTH-1:0] r_wr_data;
  logic                          r_done;
  logic                          r_error;
  logic [GROUP_NB*IMG_WIDTH-1:0] w_beat;
  logic                          w_accept;
  logic                          w_col_end;
  logic                          w_final;
  logic                          w_end;
  logic                          w_start;
  logic                          w_empty;
  logic                          w_unused;

  assign w_unused   = ^cfg_data[CFG_DWIDTH-1:MEM_AWIDTH];
  assign result_rdy = (r_state == S_WRITE);
  assign busy       = (r_state == S_WRITE);
  assign w_accept   = result_val & result_rdy;
  assign w_col_end  = (r_col == r_cols_sh - 1'b1);
  assign w_final    = w_col_end & (r_row == r_rows_sh - 1'b1);
  assign w_end      = w_accept & (w_final | result_last);
  assign w_start    = next & (r_state == S_IDLE);
  assign w_empty    = (r_cols == '0) | (r_rows == '0);

`ifdef IMAGE_WRITE_RELU_EN
  always_comb begin
    w_beat = result_bus;
    for (int i = 0; i < GROUP_NB; i++) begin
      if (result_bus[i*IMG_WIDTH + IMG_WIDTH-1]) w_beat[i*IMG_WIDTH +: IMG_WIDTH] = '0;
    end
  end
`else
  assign w_beat = result_bus;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && !w_empty) w_state_nxt = S_WRITE;
      S_WRITE: if (w_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_stride    <= '0;
      r_cols      <= '0;
      r_rows      <= '0;
      r_stride_sh <= '0;
      r_cols_sh   <= '0;
      r_rows_sh   <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_row_ptr   <= '0;
      r_wr_val    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (cfg_valid) begin
        case (cfg_addr)
          CFG_AWIDTH'(8):  r_base   <= cfg_data[MEM_AWIDTH-1:0];
          CFG_AWIDTH'(9):  r_cols   <= cfg_data;
          CFG_AWIDTH'(10): r_rows   <= cfg_data;
          CFG_AWIDTH'(11): r_stride <= cfg_data[MEM_AWIDTH-1:0];
          default: ;
        endcase
      end
      r_wr_val <= w_accept;
      r_done   <= 1'b0;
      if (w_accept) begin
        r_wr_addr <= r_row_ptr + r_col[MEM_AWIDTH-1:0];
        r_wr_data <= w_beat;
        // Row pointer advances by stride at each row wrap so no multiplier is needed.
        if (w_col_end) begin
          r_col     <= '0;
          r_row     <= r_row + 1'b1;
          r_row_ptr <= r_row_ptr + r_stride_sh;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_end) begin
        r_done <= 1'b1;
        if (result_last != w_final) r_error <= 1'b1;
      end
      if (w_start) begin
        r_cols_sh   <= r_cols;
        r_rows_sh   <= r_rows;
        r_stride_sh <= r_stride;
        r_row_ptr   <= r_base;
        r_col       <= '0;
        r_row       <= '0;
        r_error     <= 1'b0;
        if (w_empty) r_done <= 1'b1;
      end
    end
  end

  assign wr_val  = r_wr_val;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign done    = r_done;
  assign error   = r_error;

endmodule

// File: tb/tb_image_write.sv
// tb/tb_image_write.sv - directed self-checking bench for image_write
// Honours IMAGE_WRITE_RELU_EN for the lane-clamp expectations.
module tb_image_write;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic        cfg_valid = 1'b0;
  logic        next = 1'b0;
  logic [63:0] result_bus = '0;
  logic        result_last = 1'b0;
  logic        result_val = 1'b0;
  logic        result_rdy;
  logic        wr_val;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_wr_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] q_addr[$];
  logic [63:0] q_data[$];
  int          q_cyc[$];

  image_write dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .next(next), .result_bus(result_bus), .result_last(result_last), .result_val(result_val),
    .result_rdy(result_rdy), .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_val) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      if (wr_val) done_wr_cnt++;
    end
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int i);
    return {16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'h4000 + 16'(i)};
  endfunction

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic setup(input logic [31:0] b, input logic [31:0] c, input logic [31:0] r,
                       input logic [31:0] s);
    cfg_wr(5'd8, b); cfg_wr(5'd9, c); cfg_wr(5'd10, r); cfg_wr(5'd11, s);
  endtask

  task automatic pulse_next();
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic send(input int n, input int last_idx, input bit gap);
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 20 && !result_rdy; t++) @(negedge clk);
      if (!result_rdy) begin
        check($sformatf("rdy_timeout_beat%0d", i), result_rdy, 1);
        return;
      end
      result_val = 1'b1; result_bus = beat(i); result_last = (i == last_idx);
      @(negedge clk);
      result_val = 1'b0; result_last = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic check_job(input string tag, input int b, input int cols, input int stride,
                           input int nexp, input int a0, input int d0, input int dw0,
                           input bit exp_err, input int step);
    int n;
    for (int t = 0; t < 50 && done_cnt == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    n = q_addr.size() - a0;
    check({tag, "_nwr"}, n, nexp);
    for (int k = 0; k < nexp && k < n; k++) begin
      check($sformatf("%s_addr%0d", tag, k), q_addr[a0+k],
            64'((b + (k / cols) * stride + (k % cols)) & 16'hFFFF));
      check($sformatf("%s_data%0d", tag, k), q_data[a0+k], beat(k));
      if (k > 0) check($sformatf("%s_gap%0d", tag, k), q_cyc[a0+k] - q_cyc[a0+k-1], step);
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_done_with_wr"}, done_wr_cnt - dw0, 1);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, d0, dw0, b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", result_rdy, 0);
    check("rst_wr_val", wr_val, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b0;

    // Job 1: back-to-back beats; base rewrite mid-job must not affect this job
    setup(32'h100, 4, 2, 8);
    a0 = q_addr.size(); d0 = done_cnt; dw0 = done_wr_cnt;
    pulse_next();
    check("j1_busy", busy, 1);
    cfg_wr(5'd8, 32'h200);
    send(8, 7, 1'b0);
    check_job("j1", 32'h100, 4, 8, 8, a0, d0, dw0, 1'b0, 1);

    // Job 2: valid toggled each cycle
    setup(32'h100, 4, 2, 8);
    a0 = q_addr.size(); d0 = done_cnt; dw0 = done_wr_cnt;
    pulse_next();
    send(8, 7, 1'b1);
    check_job("j2", 32'h100, 4, 8, 8, a0, d0, dw0, 1'b0, 2);

    // Job 3: address wrap
    setup(32'hFFFE, 4, 1, 8);
    a0 = q_addr.size(); d0 = done_cnt; dw0 = done_wr_cnt;
    pulse_next();
    send(4, 3, 1'b0);
    check_job("j3", 32'hFFFE, 4, 8, 4, a0, d0, dw0, 1'b0, 1);

    // Job 4: early last; then a job whose final beat lacks last
    setup(32'h100, 4, 1, 8);
    a0 = q_addr.size(); d0 = done_cnt; dw0 = done_wr_cnt;
    pulse_next();
    send(2, 1, 1'b0);
    check_job("j4", 32'h100, 4, 8, 2, a0, d0, dw0, 1'b1, 1);
    a0 = q_addr.size(); d0 = done_cnt; dw0 = done_wr_cnt;
    pulse_next();
    check("j4b_error_cleared", error, 0);
    send(4, -1, 1'b0);
    check_job("j4b", 32'h100, 4, 8, 4, a0, d0, dw0, 1'b1, 1);

    // Job 5: rows=0 -> done only
    setup(32'h100, 4, 0, 8);
    a0 = q_addr.size(); b0 = busy_cnt;
    @(negedge clk);
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    check("j5_done", done, 1);
    check("j5_busy", busy, 0);
    @(posedge clk); #1;
    check("j5_done_drop", done, 0);
    repeat (3) @(negedge clk);
    check("j5_nwr", q_addr.size() - a0, 0);
    check("j5_busy_never", busy_cnt - b0, 0);

    // Job 6: lane clamp
    setup(32'h40, 1, 1, 1);
    a0 = q_addr.size();
    pulse_next();
    result_val = 1'b1; result_last = 1'b1; result_bus = 64'h0000_FFFF_7FFF_8001;
    @(negedge clk);
    result_val = 1'b0; result_last = 1'b0;
    repeat (2) @(negedge clk);
    check("j6_nwr", q_addr.size() - a0, 1);
    if (q_addr.size() > a0) begin
`ifdef IMAGE_WRITE_RELU_EN
      check("j6_data", q_data[a0], 64'h0000_0000_7FFF_0000);
`else
      check("j6_data", q_data[a0], 64'h0000_FFFF_7FFF_8001);
`endif
      check("j6_addr", q_addr[a0], 16'h40);
    end

    // Reset mid-job with a beat on the bus
    setup(32'h100, 4, 1, 8);
    pulse_next();
    a0 = q_addr.size();
    result_val = 1'b1; result_bus = beat(0);
    #1 rst = 1'b1;
    #2;
    check("rstmid_rdy", result_rdy, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_wr_val", wr_val, 0);
    @(negedge clk);
    result_val = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_nwr", q_addr.size() - a0, 0);
    check("rstmid_error", error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
